return_stack: RTL and testbench

//  Hardware return-address stack serving the controller's push/pop strobes for

---
 rtl/stack_pkg.sv | 22 ++
 rtl/ras_regfile.sv | 34 +++
 rtl/return_stack.sv | 131 +++++++++++++
 tb/tb_return_stack.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared sizing for the return-address stack and the PC-mux
//               select encoding used by the controller and fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int RAS_WIDTH = 12;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTRW  = 3;

    typedef enum logic [1:0] {
        PCSEL_NEXT = 2'd0,
        PCSEL_JMP  = 2'd1,
        PCSEL_RET  = 2'd2,
        PCSEL_BR   = 2'd3
    } pcsel_e;

endpackage
`default_nettype wire

// File: rtl/ras_regfile.sv
`default_nettype none
// ============================================================================
// Module      : ras_regfile
// Description : DEPTH x WIDTH flop array, one synchronous write port and one
//               asynchronous read port. The array is deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = RAS_WIDTH,
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTRW  = RAS_PTRW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTRW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTRW-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Hardware return-address stack: push on call, pop on return,
//               combinational top-of-stack for the PC mux return path.
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = RAS_WIDTH,
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTRW  = RAS_PTRW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic [PTRW:0]    count
);

    localparam logic [PTRW:0] c_full_count = (PTRW+1)'(DEPTH);

    logic [PTRW-1:0]  r_sp;
    logic [PTRW:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [PTRW-1:0]  w_top;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [PTRW-1:0]  w_waddr;
    logic [PTRW-1:0]  w_sp_nxt;
    logic [PTRW:0]    w_count_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [WIDTH-1:0] w_rdata;

    assign w_top   = r_sp - PTRW'(1);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);

    // Priority: flush > push&pop > push > pop. A flush writes nothing.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_sp;
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (flush) begin
            w_we = 1'b0;
        end else if (push && pop) begin
            if (!w_empty) begin
                w_we    = 1'b1;
                w_waddr = w_top;
            end else begin
                // Empty stack: behaves as a plain push, but the pop is flagged.
                w_we        = 1'b1;
                w_sp_nxt    = r_sp + PTRW'(1);
                w_count_nxt = r_count + (PTRW+1)'(1);
                w_unf_set   = 1'b1;
            end
        end else if (push) begin
            if (!w_full) begin
                w_we        = 1'b1;
                w_sp_nxt    = r_sp + PTRW'(1);
                w_count_nxt = r_count + (PTRW+1)'(1);
            end else begin
                w_ovf_set = 1'b1;
            end
        end else if (pop) begin
            if (!w_empty) begin
                w_sp_nxt    = w_top;
                w_count_nxt = r_count - (PTRW+1)'(1);
            end else begin
                w_unf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= r_overflow | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    ras_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_regfile (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (dataIn),
        .raddr (w_top),
        .rdata (w_rdata)
    );

    // Storage is unreset, so the read data is masked while empty.
    assign dataOut   = w_empty ? '0 : w_rdata;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_stack
// Description : Directed and scoreboard-checked bench for return_stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        pop;
    logic        flush;
    logic [11:0] dataIn;
    logic [11:0] dataOut;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] d;
        logic [3:0]  c;
        logic        e;
        logic        f;
        logic        o;
        logic        u;
    } exp_t;

    exp_t        sbq[$];
    logic [11:0] mdl[$];
    logic        m_o;
    logic        m_u;

    always #5 clk = ~clk;

    return_stack dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation for one edge; outputs are checked before that edge
    // against the reference stack state, then the reference is advanced.
    task automatic op(input logic p, input logic q, input logic f, input logic [11:0] d);
        exp_t x;
        push   = p;
        pop    = q;
        flush  = f;
        dataIn = d;
        x.d = (mdl.size() > 0) ? mdl[$] : 12'h000;
        x.c = 4'(mdl.size());
        x.e = (mdl.size() == 0);
        x.f = (mdl.size() == 8);
        x.o = m_o;
        x.u = m_u;
        sbq.push_back(x);
        if (f) begin
            mdl.delete();
            m_o = 1'b0;
            m_u = 1'b0;
        end else if (p && q) begin
            if (mdl.size() > 0) mdl[$] = d;
            else begin
                mdl.push_back(d);
                m_u = 1'b1;
            end
        end else if (p) begin
            if (mdl.size() < 8) mdl.push_back(d);
            else m_o = 1'b1;
        end else if (q) begin
            if (mdl.size() > 0) void'(mdl.pop_back());
            else m_u = 1'b1;
        end
        @(negedge clk);
        x = sbq.pop_front();
        check("dataOut",   32'(dataOut),   32'(x.d));
        check("count",     32'(count),     32'(x.c));
        check("empty",     32'(empty),     32'(x.e));
        check("full",      32'(full),      32'(x.f));
        check("overflow",  32'(overflow),  32'(x.o));
        check("underflow", 32'(underflow), 32'(x.u));
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; dataIn = '0;
        m_o = 1'b0; m_u = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) op(0, 0, 0, 12'h000);

        // LIFO order
        op(1, 0, 0, 12'h010); op(1, 0, 0, 12'h020); op(1, 0, 0, 12'h030);
        op(0, 1, 0, 0); op(0, 1, 0, 0); op(0, 1, 0, 0);
        op(0, 0, 0, 0);

        // Full and overflow
        for (int i = 0; i < 8; i++) op(1, 0, 0, 12'h100 + 12'(i));
        op(1, 0, 0, 12'h1FF);
        check("ovf_top", 32'(dataOut), 32'h107);
        check("ovf_cnt", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) op(0, 1, 0, 0);

        // Underflow, then push keeps the sticky flag
        op(0, 1, 0, 0);
        op(1, 0, 0, 12'h055);
        check("unf_top", 32'(dataOut), 32'h055);
        check("unf_sticky", 32'(underflow), 32'd1);
        op(0, 1, 0, 0);

        // Simultaneous push&pop, including on an empty stack
        op(1, 0, 0, 12'h011); op(1, 0, 0, 12'h022);
        op(1, 1, 0, 12'h0AA);
        check("pp_top", 32'(dataOut), 32'h0AA);
        check("pp_cnt", 32'(count), 32'd2);
        op(0, 1, 0, 0);
        check("pp_pop", 32'(dataOut), 32'h011);
        op(0, 1, 0, 0);
        op(1, 1, 0, 12'h0BB);
        op(0, 0, 0, 0);

        // Flush with 3 entries, flush beating push
        op(1, 0, 0, 12'h201); op(1, 0, 0, 12'h202);
        op(1, 0, 1, 12'h203);
        op(1, 0, 0, 12'h301); op(1, 0, 0, 12'h302); op(1, 0, 0, 12'h303);
        op(0, 0, 1, 0);
        op(0, 0, 0, 0);

        // Refill, then async reset in mid-cycle
        op(1, 0, 0, 12'h401); op(1, 0, 0, 12'h402);
        #1;
        rst = 1'b1;
        #1;
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(count), 32'd0);
        check("arst_dout",  32'(dataOut), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl.delete(); m_o = 1'b0; m_u = 1'b0;
        op(0, 0, 0, 0);

        // Move sp away from zero, then pairs that cross the pointer wrap
        for (int i = 0; i < 6; i++) op(1, 0, 0, 12'h500 + 12'(i));
        for (int i = 0; i < 6; i++) op(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            op(1, 0, 0, 12'($urandom));
            if (i % 2 == 0) op(1, 1, 0, 12'($urandom));
            else            op(0, 1, 0, 0);
        end
        for (int i = 0; i < 9; i++) op(0, 1, 0, 0);
        op(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
